// File: rtl/moore_pkg.sv
// rtl/moore_pkg.sv - shared types and constants for the Moore sequence detector
package moore_pkg;

  // Match mode: overlapping keeps the matched history after a hit,
  // non-overlapping restarts from an empty history.
  typedef enum logic {
    MODE_NONOVERLAP = 1'b0,
    MODE_OVERLAP    = 1'b1
  } mode_e;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

  // States S0..SN need clog2(N+1) bits.
  function automatic int state_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/moore_seq_next.sv
// rtl/moore_seq_next.sv - combinational next-state (prefix fallback) for the detector
//   state     : current matched-prefix length k
//   x         : incoming serial bit
//   pattern   : pattern, bit [PATTERN_W-1] expected first
//   mode      : overlap / non-overlap
//   state_nxt : longest prefix of pattern that is a suffix of (prefix_k', x)
module moore_seq_next
  import moore_pkg::*;
#(
  parameter int PATTERN_W = 4
) (
  input  logic [state_w(PATTERN_W)-1:0] state,
  input  logic                          x,
  input  logic [PATTERN_W-1:0]          pattern,
  input  mode_e                         mode,
  output logic [state_w(PATTERN_W)-1:0] state_nxt
);

  localparam int N  = PATTERN_W;
  localparam int SW = state_w(PATTERN_W);

  always_comb begin : next_calc
    int ks;
    int kp;
    logic [N-1:0] cand;
    logic [N-1:0] pref;
    logic [N-1:0] mask;

    ks = int'(state);
    // Illegal encodings and a completed non-overlap match both restart
    // from an empty history.
    if (ks > N) begin
      kp = 0;
    end else if (mode == MODE_NONOVERLAP && ks == N) begin
      kp = 0;
    end else begin
      kp = ks;
    end

    // cand holds the first kp pattern bits followed by x, right-aligned so
    // bit 0 is the newest bit. Bits above kp are zero and masked below.
    cand = ((pattern >> (N - kp)) << 1) | {{(N-1){1'b0}}, x};

    state_nxt = '0;
    pref      = '0;
    mask      = '0;
    // Ascending scan: the last qualifying j is the longest fallback.
    for (int j = 1; j <= N; j++) begin
      pref = pattern >> (N - j);
      mask = {N{1'b1}} >> (N - j);
      if (j <= kp + 1 && ((cand ^ pref) & mask) == '0) begin
        state_nxt = j[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/moore_seq_detector.sv
// rtl/moore_seq_detector.sv - runtime-loadable Moore serial pattern detector with match counter
//   clk, rst            : clock, asynchronous active-high reset
//   en, x               : sample enable and serial bit
//   pat_load, pat_in,
//   ovl_in              : synchronous load of pattern and match mode
//   cnt_clr             : synchronous clear of match_cnt
//   y                   : high while in the full-match state
//   match_cnt           : saturating match count
//   state_o             : matched-prefix length
module moore_seq_detector
  import moore_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = DEFAULT_PATTERN,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          x,
  input  logic                          pat_load,
  input  logic [PATTERN_W-1:0]          pat_in,
  input  logic                          ovl_in,
  input  logic                          cnt_clr,
  output logic                          y,
  output logic [CNT_W-1:0]              match_cnt,
  output logic [state_w(PATTERN_W)-1:0] state_o
);

  localparam int              SW     = state_w(PATTERN_W);
  localparam logic [SW-1:0]   S_FULL = SW'(PATTERN_W);

  logic [PATTERN_W-1:0] pattern_q;
  mode_e                mode_q;
  logic [SW-1:0]        state_q;
  logic [SW-1:0]        state_nxt;
  logic                 state_bad;
  logic                 hit;

  moore_seq_next #(
    .PATTERN_W (PATTERN_W)
  ) u_next (
    .state     (state_q),
    .x         (x),
    .pattern   (pattern_q),
    .mode      (mode_q),
    .state_nxt (state_nxt)
  );

  assign state_bad = (state_q > S_FULL);
  assign hit       = en && !state_bad && (state_nxt == S_FULL);
  assign state_o   = state_q;

  // y is registered alongside the state so it always equals (state_q == SN).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= PATTERN;
      mode_q    <= mode_e'(OVERLAP);
      state_q   <= '0;
      y         <= 1'b0;
      match_cnt <= '0;
    end else if (pat_load) begin
      pattern_q <= pat_in;
      mode_q    <= mode_e'(ovl_in);
      state_q   <= '0;
      y         <= 1'b0;
      match_cnt <= '0;
    end else begin
      if (state_bad) begin
        state_q <= '0;
        y       <= 1'b0;
      end else if (en) begin
        state_q <= state_nxt;
        y       <= (state_nxt == S_FULL);
      end

      if (cnt_clr) begin
        match_cnt <= '0;
      end else if (hit && match_cnt != {CNT_W{1'b1}}) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_moore_seq_detector.sv
// tb/tb_moore_seq_detector.sv - scoreboard bench for moore_seq_detector
module tb_moore_seq_detector;

  localparam int PW      = 4;
  localparam int CW      = 2;
  localparam int SW      = 3;
  localparam int CNT_MAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          x;
  logic          pat_load;
  logic [PW-1:0] pat_in;
  logic          ovl_in;
  logic          cnt_clr;
  logic          y;
  logic [CW-1:0] match_cnt;
  logic [SW-1:0] state_o;

  moore_seq_detector #(
    .PATTERN_W (PW),
    .PATTERN   (4'b1011),
    .OVERLAP   (1'b1),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .x         (x),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .ovl_in    (ovl_in),
    .cnt_clr   (cnt_clr),
    .y         (y),
    .match_cnt (match_cnt),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    int st;
    int cnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: keeps the accepted-bit history and searches it directly.
  logic [PW-1:0] m_pat;
  bit            m_ovl;
  int            m_st;
  int            m_cnt;
  bit            hist[$];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int model_match();
    int best = 0;
    int lim  = (hist.size() < PW) ? hist.size() : PW;
    for (int j = 1; j <= lim; j++) begin
      bit ok = 1'b1;
      for (int m = 0; m < j; m++) begin
        if (hist[hist.size() - j + m] != m_pat[PW-1-m]) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  task automatic model_reset();
    m_pat = 4'b1011;
    m_ovl = 1'b1;
    m_st  = 0;
    m_cnt = 0;
    hist.delete();
  endtask

  task automatic model_step(input bit e, input bit xb, input bit ld,
                            input logic [PW-1:0] p, input bit o, input bit c);
    int nxt;
    if (ld) begin
      m_pat = p;
      m_ovl = o;
      m_st  = 0;
      m_cnt = 0;
      hist.delete();
    end else begin
      nxt = m_st;
      if (e) begin
        if (!m_ovl && m_st == PW) hist.delete();
        hist.push_back(xb);
        if (hist.size() > PW) void'(hist.pop_front());
        nxt = model_match();
      end
      if (c) m_cnt = 0;
      else if (e && nxt == PW && m_cnt < CNT_MAX) m_cnt++;
      m_st = nxt;
    end
  endtask

  task automatic step(input string tag, input bit e, input bit xb, input bit ld,
                      input logic [PW-1:0] p, input bit o, input bit c);
    exp_t ex;
    exp_t got;
    @(negedge clk);
    en       = e;
    x        = xb;
    pat_load = ld;
    pat_in   = p;
    ovl_in   = o;
    cnt_clr  = c;
    model_step(e, xb, ld, p, o, c);
    ex.y   = (m_st == PW) ? 1 : 0;
    ex.st  = m_st;
    ex.cnt = m_cnt;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_eq({tag, ".y"},   int'(y),         got.y);
    check_eq({tag, ".st"},  int'(state_o),   got.st);
    check_eq({tag, ".cnt"}, int'(match_cnt), got.cnt);
  endtask

  task automatic send(input string tag, input bit xb);
    step(tag, 1'b1, xb, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic load(input string tag, input logic [PW-1:0] p, input bit o);
    step(tag, 1'b0, 1'b0, 1'b1, p, o, 1'b0);
  endtask

  // Asserts rst between clock edges and checks outputs before any edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    en       = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq({tag, ".y"},   int'(y),         0);
    check_eq({tag, ".st"},  int'(state_o),   0);
    check_eq({tag, ".cnt"}, int'(match_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  bit stream[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    x        = 1'b0;
    pat_load = 1'b0;
    pat_in   = '0;
    ovl_in   = 1'b0;
    cnt_clr  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst.y",   int'(y),         0);
    check_eq("rst.st",  int'(state_o),   0);
    check_eq("rst.cnt", int'(match_cnt), 0);
    rst = 1'b0;

    // Reach a match, then reset asynchronously mid-cycle.
    send("pre", 1'b1);
    send("pre", 1'b0);
    send("pre", 1'b1);
    send("pre", 1'b1);
    async_reset("arst");

    // Overlapping, default pattern 1011.
    foreach (stream[i]) send("ovl", stream[i]);
    check_eq("ovl.final_cnt", int'(match_cnt), 2);
    check_eq("ovl.final_st",  int'(state_o),   4);

    // Non-overlapping.
    load("ld_no", 4'b1011, 1'b0);
    foreach (stream[i]) send("novl", stream[i]);
    check_eq("novl.final_cnt", int'(match_cnt), 1);
    check_eq("novl.final_st",  int'(state_o),   1);

    // Enable gating.
    load("ld_en", 4'b1011, 1'b1);
    send("en", 1'b1);
    send("en", 1'b0);
    repeat (3) step("en_off", 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    send("en", 1'b1);
    send("en", 1'b1);
    check_eq("en.final_y", int'(y), 1);

    // Runtime load and counter saturation.
    load("ld_sat", 4'b1111, 1'b1);
    repeat (8) send("sat", 1'b1);
    check_eq("sat.cnt", int'(match_cnt), 3);
    step("clr", 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    check_eq("clr.cnt", int'(match_cnt), 0);
    check_eq("clr.y",   int'(y),         1);

    // Reset mid-match loses the partial prefix and restores the default pattern.
    load("ld_mid", 4'b0110, 1'b0);
    send("mid", 1'b1);
    send("mid", 1'b0);
    send("mid", 1'b1);
    async_reset("mid_rst");
    send("mid_after", 1'b1);
    check_eq("mid.st", int'(state_o), 1);
    check_eq("mid.y",  int'(y),       0);

    // Randomised traffic with periodic pattern reloads and counter clears.
    for (int i = 0; i < 120; i++) begin
      if (i % 20 == 0) begin
        load("rnd_ld", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end else begin
        step("rnd", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'b0, 4'b0000, 1'b0, ($urandom_range(0, 15) == 0));
      end
    end

    check_eq("sb.empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
- Parametrised Moore-style serial pattern detector; the next generation of the team's small hand-coded Moore FSMs.
- Tracks a single-bit input stream against a PATTERN_W-bit pattern, loadable at runtime.
- Supports overlapping and non-overlapping match modes and keeps a saturating match counter.
- Sits on serial/control bit streams as a reusable detector for framing, sync-word and command decoding.

Parameters:
- PATTERN_W, 4, pattern length in bits (>=2).
- PATTERN, 4'b1011, reset-value pattern; bit [PATTERN_W-1] is the first bit expected.
- OVERLAP, 1, reset-value match mode: 1 = overlapping, 0 = non-overlapping.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample enable; x is consumed only on edges where en=1.
- x  in  1  serial data bit.
- pat_load  in  1  synchronous load of pat_in and ovl_in.
- pat_in  in  PATTERN_W  new pattern, MSB first.
- ovl_in  in  1  new match mode.
- cnt_clr  in  1  synchronous clear of match_cnt.
- y  out  1  Moore match flag.
- match_cnt  out  CNT_W  saturating count of matches.
- state_o  out  clog2(PATTERN_W+1)  current matched-prefix length, for debug.

Behaviour:
- Reset is decided: rst, asynchronous, active-high; clock clk.
- Reset values: pattern register = PATTERN, mode = OVERLAP, state = 0, y = 0, match_cnt = 0.
- States: S0..SN, N = PATTERN_W. Sk means the last k accepted bits equal the first k bits of the pattern.
- y = 1 iff state == SN. y is decoded from the state register only (Moore), never from x.
- Latency: the final pattern bit is sampled on edge t; y is high from t until the next state change.
- Next state for en=1, pat_load=0:
  - Let k' = k. In non-overlap mode, k' = 0 when k == N.
  - Form s = first k' pattern bits followed by x.
  - New state = largest j <= min(k'+1, N) such that the last j bits of s equal the first j pattern bits (prefix/suffix fallback, KMP-equivalent).
- Overlap mode: from SN the history is the full pattern, so sequences sharing bits re-match; pattern 1111 stays in SN on every further 1.
- en=0: state, y and match_cnt hold. y stays high if already in SN.
- pat_load=1 (priority over en):
  - pattern <= pat_in, mode <= ovl_in, state <= S0, match_cnt <= 0.
  - x is ignored that cycle.
- match_cnt increments by 1 on every edge where the computed next state is SN and en=1. This includes SN->SN in overlap mode.
- match_cnt saturates at 2^CNT_W-1; no wrap.
- cnt_clr=1: match_cnt <= 0. A coincident increment is dropped; state still advances normally.
- rst mid-sequence: immediate return to S0, y=0, count 0, pattern back to PATTERN. Partial matches are lost.
- No X-propagation on unused state encodings: any encoding > N is forced to S0 on the next edge.

Decomposition:
- Shared package moore_pkg:
  - state-width function clog2(N+1)
  - MODE_OVERLAP / MODE_NONOVERLAP constants
  - default pattern constant
- Sub-module moore_seq_next: purely combinational, computes the next state from (state, x, pattern, mode). Keeps the prefix-fallback loop separate from the register/counter logic so it can be checked exhaustively on its own.
- Top holds the pattern/mode registers, the state register, y decode and the counter.

Test Plan:
- Reset: assert rst async mid-cycle with defaults -> y=0, match_cnt=0, state_o=0 immediately, without waiting for a clock.
- Overlap, pattern 1011, en=1, x stream 1,0,1,1,0,1,1 -> y high after the 4th and 7th bits; match_cnt=2; state_o=4 at the end.
- Non-overlap (pat_load with pat_in=1011, ovl_in=0), same stream -> y high only after the 4th bit; final state_o=1; match_cnt=1.
- Enable gating: pattern 1011; send 1,0; then en=0 for three cycles with x=1; then en=1 with 1,1 -> y high only after the last bit; state_o stays 2 during the en=0 cycles.
- Runtime load plus saturation, CNT_W=2: load 1111 in overlap mode, send eight 1s -> y high from the 4th bit onward; match_cnt reaches 3 and holds.
  - Then cnt_clr=1 with x=1 -> match_cnt=0 and y stays 1.
- Reset mid-match: pattern 1011; send 1,0,1; pulse rst; send 1 -> no match; state_o=1; y=0.
